// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// One product/quotient bit per CALC cycle, plus a final sign-correction cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   opb_q;
    logic              is_div_q;
    logic              sel_hi_q;
    logic              sel_rem_q;
    logic              neg_q;
    logic [4:0]        tag_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_addr_q;

    // Operand decode on the accept cycle
    logic            accept;
    logic            rs1_signed;
    logic            rs2_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            is_div_d;
    logic            neg_d;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign accept      = (state_q == IDLE) && i_start && !i_flush;
    assign rs1_signed  = (i_func3 != 3'b011) && (i_func3 != 3'b101) && (i_func3 != 3'b111);
    assign rs2_signed  = rs1_signed && (i_func3 != 3'b010);
    assign a_neg       = rs1_signed && i_rs1[XLEN-1];
    assign b_neg       = rs2_signed && i_rs2[XLEN-1];
    assign a_mag       = a_neg ? -i_rs1 : i_rs1;
    assign b_mag       = b_neg ? -i_rs2 : i_rs2;
    assign is_div_d    = i_func3[2];
    // Remainder follows the dividend; product and quotient follow the sign XOR
    assign neg_d       = (is_div_d && i_func3[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero    = is_div_d && (i_rs2 == '0);
    assign div_ovf     = is_div_d && rs1_signed && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    assign special_res = div_zero ? (i_func3[1] ? i_rs1 : '1)
                                  : (i_func3[1] ? '0 : i_rs1);

    // Per-iteration datapath
    logic [2*XLEN-1:0] mul_acc_d;
    logic [XLEN:0]     div_tmp;
    logic [XLEN:0]     div_diff;
    logic              div_fit;
    logic [2*XLEN-1:0] div_acc_d;

    assign mul_acc_d = acc_q + (opb_q[0] ? mcand_q : '0);
    // acc_q holds {remainder, dividend/quotient}; shift left one bit and trial-subtract
    assign div_tmp   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_tmp - {1'b0, opb_q};
    assign div_fit   = div_tmp[XLEN] || !div_diff[XLEN];
    assign div_acc_d = {(div_fit ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_fit};

    // Correction cycle: sign fix-up and half/quotient/remainder selection
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   mul_res_d;
    logic [XLEN-1:0]   div_val_d;
    logic [XLEN-1:0]   div_res_d;
    logic [XLEN-1:0]   result_d;

    assign prod_d    = neg_q ? -acc_q : acc_q;
    assign mul_res_d = sel_hi_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
    assign div_val_d = sel_rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_res_d = neg_q ? -div_val_d : div_val_d;
    assign result_d  = is_div_q ? div_res_d : mul_res_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            sel_rem_q <= 1'b0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        is_div_q  <= is_div_d;
                        sel_hi_q  <= (i_func3[1:0] != 2'b00);
                        sel_rem_q <= i_func3[1];
                        neg_q     <= neg_d;
                        tag_q     <= i_rd_addr;
                        opb_q     <= b_mag;
                        mcand_q   <= {{XLEN{1'b0}}, a_mag};
                        acc_q     <= is_div_d ? {{XLEN{1'b0}}, a_mag} : '0;
                        if (div_zero || div_ovf) begin
                            result_q  <= special_res;
                            rd_addr_q <= i_rd_addr;
                            state_q   <= DONE;
                        end else begin
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q  <= result_d;
                        rd_addr_q <= tag_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_div_q) begin
                            acc_q <= div_acc_d;
                        end else begin
                            acc_q   <= mul_acc_d;
                            mcand_q <= {mcand_q[2*XLEN-2:0], 1'b0};
                            opb_q   <= {1'b0, opb_q[XLEN-1:1]};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (state_q != IDLE);
    // A flush landing on the DONE cycle suppresses the strobe
    assign o_valid   = (state_q == DONE) && !i_flush;
    assign o_result  = result_q;
    assign o_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, random ops against a
// behavioural model, flush/reset/ignored-start handling and latency checks.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_addr;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_func3   (func3),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_rd_addr (rd_addr),
        .i_flush   (flush),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_result  (result),
        .o_rd_addr (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference for the random ops
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] zb64;
        logic signed [63:0] p;
        logic [63:0]        up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa   = a;
        sb   = b;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        zb64 = {32'd0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa64 * sb64; return p[31:0]; end
            3'b001: begin p = sa64 * sb64; return p[63:32]; end
            3'b010: begin p = sa64 * zb64; return p[63:32]; end
            3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sr = sa / sb;
                return sr;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return XLEN + 2;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && valid) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_valid", {63'd0, valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", {32'd0, result}, {32'd0, e.res});
                chk("rd_addr", {59'd0, rd_out}, {59'd0, e.rd});
                $display("op done: result=0x%08h rd=%0d", result, rd_out);
            end
        end
    end

    // Drive a request and return just after its accept edge
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        @(posedge clk);
        #1;
        start   = 1'b1;
        func3   = f;
        rs1     = a;
        rs2     = b;
        rd_addr = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges from accept to the strobe; busy must stay high meanwhile and drop after
    task automatic wait_valid(input string tag, input int lat);
        int n;
        int busy_bad;
        bit seen;
        n        = 0;
        busy_bad = 0;
        seen     = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (valid) seen = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
        chk({tag, "_lat"}, 64'(n + 1), 64'(lat));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int lat);
        exp_t e;
        e.res = exp_res;
        e.rd  = rd;
        sb_q.push_back(e);
        $display("op %s: f3=%0d a=0x%08h b=0x%08h rd=%0d exp=0x%08h", tag, f, a, b, rd, exp_res);
        launch(f, a, b, rd);
        wait_valid(tag, lat);
    endtask

    initial begin
        int vc;
        rst = 1'b1; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0; rd_addr = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_rd", {59'd0, rd_out}, 64'd0);
        rst = 1'b0;

        do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34);
        do_op("divu",   3'b101, 32'd7,        32'd2, 5'd5, 32'd3, 34);
        do_op("remu",   3'b111, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'd1, 34);
        do_op("div0",   3'b100, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 1);
        do_op("remu0",  3'b111, 32'h1234, 32'd0, 5'd7, 32'h1234, 1);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1);

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rd = 5'($urandom_range(0, 31));
            do_op("rand", f, a, b, rd, ref_op(f, a, b), exp_lat(f, a, b));
        end

        // Flush 10 cycles after accept, with ignored start pulses while busy
        vc = valid_cnt;
        launch(3'b011, 32'h1111_1111, 32'h2222_2222, 5'd10);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        chk("flush_no_valid", 64'(valid_cnt), 64'(vc));
        chk("flush_keeps_result", {32'd0, result}, {32'd0, sb_last_res()});

        // New op after flush, with start pulses during its CALC: exactly one strobe
        vc = valid_cnt;
        begin
            exp_t e;
            e.res = 32'hFFFF_FFFE;
            e.rd  = 5'd11;
            sb_q.push_back(e);
        end
        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        chk("busy_start_ignored", 64'(valid_cnt), 64'(vc + 1));

        // Reset in the middle of CALC clears every output
        launch(3'b101, 32'd1000, 32'd7, 5'd12);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_valid", {63'd0, valid}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_rd", {59'd0, rd_out}, 64'd0);
        rst = 1'b0;

        // Flush together with start in IDLE blocks the accept
        vc = valid_cnt;
        @(posedge clk);
        #1;
        start = 1'b1; flush = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; rd_addr = 5'd13;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        chk("flush_start_no_valid", 64'(valid_cnt), 64'(vc));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Last completed result before the flush test: the final random op's expectation
    logic [31:0] last_res;
    always @(negedge clk) begin
        if (!rst && valid) last_res <= result;
    end
    function automatic logic [31:0] sb_last_res();
        return last_res;
    endfunction

endmodule
